// File: rtl/bemf_sequencer.sv
// ---------------------------------------------------------------------------
// bemf_sequencer
//   Sweeps motors 0..3 once per start request. For each motor it converts the
//   high-side (channel 2m) and low-side (channel 2m+1) back-EMF samples, hands
//   them with the current accumulator and calibration offset to an external
//   update pipeline, and writes the pipeline result back into the motor's
//   16-bit accumulator. An unanswered conversion flags adc_err and skips the
//   motor.
//
// Ports
//   clk, reset                 single clock, synchronous active-high reset
//   start                      one-cycle sweep request (ignored while busy)
//   adc_go, adc_chan           conversion request / channel to the ADC
//   adc_valid, adc_data        conversion result strobe / data
//   calib0..calib3             per-motor calibration offsets
//   bemf_clear                 per-motor accumulator clear (wins over write-back)
//   bemf_adc_h, bemf_adc_l     captured samples towards the update pipeline
//   upd_valid, upd_mot_sel,
//   upd_bemf, upd_calib        issue side of the update pipeline
//   res_valid, res_mot_sel,
//   res_bemf                   result side of the update pipeline
//   bemf0..bemf3               current accumulators
//   busy, sweep_done, adc_err  status: sweep active, end pulse, sticky timeout
// ---------------------------------------------------------------------------
module bemf_sequencer #(
  parameter int ADC_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        adc_go,
  output logic [2:0]  adc_chan,
  input  logic        adc_valid,
  input  logic [9:0]  adc_data,
  input  logic [15:0] calib0,
  input  logic [15:0] calib1,
  input  logic [15:0] calib2,
  input  logic [15:0] calib3,
  input  logic [3:0]  bemf_clear,
  output logic [9:0]  bemf_adc_h,
  output logic [9:0]  bemf_adc_l,
  output logic [1:0]  upd_mot_sel,
  output logic        upd_valid,
  output logic [15:0] upd_bemf,
  output logic [15:0] upd_calib,
  input  logic [15:0] res_bemf,
  input  logic [1:0]  res_mot_sel,
  input  logic        res_valid,
  output logic [15:0] bemf0,
  output logic [15:0] bemf1,
  output logic [15:0] bemf2,
  output logic [15:0] bemf3,
  output logic        busy,
  output logic        sweep_done,
  output logic        adc_err
);

  // The counter only has to reach ADC_TIMEOUT-1: the wait lasts ADC_TIMEOUT cycles.
  localparam int CW = (ADC_TIMEOUT < 2) ? 1 : $clog2(ADC_TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(ADC_TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    REQ_H    = 3'd1,
    WAIT_H   = 3'd2,
    REQ_L    = 3'd3,
    WAIT_L   = 3'd4,
    ISSUE    = 3'd5,
    WAIT_RES = 3'd6,
    NEXT     = 3'd7
  } state_e;

  state_e         state_q, state_d;
  logic [1:0]     m_q, m_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [9:0]     samp_h_q, samp_h_d;
  logic [9:0]     samp_l_q, samp_l_d;
  logic           adc_err_q, adc_err_d;
  logic [15:0]    bemf_q [4];
  logic [15:0]    bemf_d [4];
  logic           adc_go_q, adc_go_d;
  logic [2:0]     adc_chan_q, adc_chan_d;
  logic           upd_valid_q, upd_valid_d;
  logic [1:0]     upd_mot_sel_q, upd_mot_sel_d;
  logic [15:0]    upd_bemf_q, upd_bemf_d;
  logic [15:0]    upd_calib_q, upd_calib_d;
  logic           busy_q, busy_d;
  logic           sweep_done_q, sweep_done_d;

  function automatic logic [15:0] calib_pick(input logic [1:0] sel,
                                             input logic [15:0] c0, input logic [15:0] c1,
                                             input logic [15:0] c2, input logic [15:0] c3);
    logic [15:0] r;
    case (sel)
      2'd0:    r = c0;
      2'd1:    r = c1;
      2'd2:    r = c2;
      2'd3:    r = c3;
      default: r = 16'd0;
    endcase
    return r;
  endfunction

  // Next-state, datapath and registered-output decode.
  always_comb begin
    state_d   = state_q;
    m_d       = m_q;
    cnt_d     = cnt_q;
    samp_h_d  = samp_h_q;
    samp_l_d  = samp_l_q;
    adc_err_d = adc_err_q;
    bemf_d    = bemf_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          m_d       = 2'd0;
          adc_err_d = 1'b0;
          state_d   = REQ_H;
        end else begin
          state_d = IDLE;
        end
      end
      REQ_H: begin
        cnt_d   = {CW{1'b0}};
        state_d = WAIT_H;
      end
      WAIT_H: begin
        if (adc_valid) begin
          samp_h_d = adc_data;
          state_d  = REQ_L;
        end else if (cnt_q == CNT_LAST) begin
          adc_err_d = 1'b1;
          state_d   = NEXT;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      REQ_L: begin
        cnt_d   = {CW{1'b0}};
        state_d = WAIT_L;
      end
      WAIT_L: begin
        if (adc_valid) begin
          samp_l_d = adc_data;
          state_d  = ISSUE;
        end else if (cnt_q == CNT_LAST) begin
          adc_err_d = 1'b1;
          state_d   = NEXT;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ISSUE: begin
        state_d = WAIT_RES;
      end
      WAIT_RES: begin
        // Results tagged for another motor are stale and dropped.
        if (res_valid && (res_mot_sel == m_q)) begin
          bemf_d[m_q] = res_bemf;
          state_d     = NEXT;
        end else begin
          state_d = WAIT_RES;
        end
      end
      NEXT: begin
        if (m_q == 2'd3) begin
          state_d = IDLE;
        end else begin
          m_d     = m_q + 2'd1;
          state_d = REQ_H;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Applied after the write-back so a coincident clear takes priority.
    for (int k = 0; k < 4; k++) begin
      if (bemf_clear[k]) begin
        bemf_d[k] = 16'd0;
      end else begin
        bemf_d[k] = bemf_d[k];
      end
    end

    // Outputs are decoded from the next state so the registers line up with it.
    adc_go_d     = (state_d == REQ_H) || (state_d == REQ_L);
    busy_d       = (state_d != IDLE);
    sweep_done_d = (state_d == NEXT) && (m_q == 2'd3);
    upd_valid_d  = (state_d == ISSUE);

    if (state_d == REQ_H) begin
      adc_chan_d = {m_d, 1'b0};
    end else if (state_d == REQ_L) begin
      adc_chan_d = {m_d, 1'b1};
    end else begin
      adc_chan_d = adc_chan_q;
    end

    // bemf_d reflects any clear on this edge, i.e. the value seen during ISSUE.
    if (state_d == ISSUE) begin
      upd_mot_sel_d = m_q;
      upd_bemf_d    = bemf_d[m_q];
      upd_calib_d   = calib_pick(m_q, calib0, calib1, calib2, calib3);
    end else begin
      upd_mot_sel_d = upd_mot_sel_q;
      upd_bemf_d    = upd_bemf_q;
      upd_calib_d   = upd_calib_q;
    end
  end

  // State, datapath and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      m_q           <= 2'd0;
      cnt_q         <= {CW{1'b0}};
      samp_h_q      <= 10'd0;
      samp_l_q      <= 10'd0;
      adc_err_q     <= 1'b0;
      for (int k = 0; k < 4; k++) begin
        bemf_q[k] <= 16'd0;
      end
      adc_go_q      <= 1'b0;
      adc_chan_q    <= 3'd0;
      upd_valid_q   <= 1'b0;
      upd_mot_sel_q <= 2'd0;
      upd_bemf_q    <= 16'd0;
      upd_calib_q   <= 16'd0;
      busy_q        <= 1'b0;
      sweep_done_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      m_q           <= m_d;
      cnt_q         <= cnt_d;
      samp_h_q      <= samp_h_d;
      samp_l_q      <= samp_l_d;
      adc_err_q     <= adc_err_d;
      bemf_q        <= bemf_d;
      adc_go_q      <= adc_go_d;
      adc_chan_q    <= adc_chan_d;
      upd_valid_q   <= upd_valid_d;
      upd_mot_sel_q <= upd_mot_sel_d;
      upd_bemf_q    <= upd_bemf_d;
      upd_calib_q   <= upd_calib_d;
      busy_q        <= busy_d;
      sweep_done_q  <= sweep_done_d;
    end
  end

  assign adc_go      = adc_go_q;
  assign adc_chan    = adc_chan_q;
  assign bemf_adc_h  = samp_h_q;
  assign bemf_adc_l  = samp_l_q;
  assign upd_valid   = upd_valid_q;
  assign upd_mot_sel = upd_mot_sel_q;
  assign upd_bemf    = upd_bemf_q;
  assign upd_calib   = upd_calib_q;
  assign bemf0       = bemf_q[0];
  assign bemf1       = bemf_q[1];
  assign bemf2       = bemf_q[2];
  assign bemf3       = bemf_q[3];
  assign busy        = busy_q;
  assign sweep_done  = sweep_done_q;
  assign adc_err     = adc_err_q;

endmodule
